// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter, N data bits,
// optional odd/even parity, 1-2 stop bits, one-entry holding register.
// Ports: clk, reset_n (async low), tx_valid/tx_data/tx_ready byte input,
// tx_serial (registered line, idle high), tx_busy, tx_done (frame end pulse).
module uart_tx_frame #(
  parameter int FREQUENCY = 10000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = FREQUENCY / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_frame: PARITY must be 0..2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 par_q, par_d;
  logic                 tx_serial_q, tx_serial_d;

  logic          last;
  logic          load;
  logic [CW-1:0] cnt_inc;

  assign last    = (cnt_q == CNT_LAST);
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;

    // ready is !hold_full, so fill and drain never overlap
    if (tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = tx_data;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        load  = hold_full_q;
      end
      S_START: begin
        cnt_d = last ? '0 : cnt_inc;
        if (last) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        cnt_d = last ? '0 : cnt_inc;
        if (last) begin
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        cnt_d = last ? '0 : cnt_inc;
        if (last) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        cnt_d = last ? '0 : cnt_inc;
        if (last) begin
          if (idx_q == STOP_LAST) begin
            // chain straight into the next start bit
            load    = hold_full_q;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      par_d       = (^hold_q) ^ PAR_ODD;
      hold_full_d = 1'b0;
      idx_d       = '0;
      cnt_d       = '0;
      state_d     = S_START;
    end

    // line value follows the state being entered
    unique case (state_d)
      S_START:  tx_serial_d = 1'b0;
      S_DATA:   tx_serial_d = shift_d[0];
      S_PARITY: tx_serial_d = par_d;
      default:  tx_serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      tx_serial_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      tx_serial_q <= tx_serial_d;
    end
  end

  assign tx_ready  = !hold_full_q;
  assign tx_serial = tx_serial_q;
  assign tx_busy   = (state_q != S_IDLE);
  assign tx_done   = (state_q == S_STOP) && last
                  && (idx_q == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame.
// Four instances: 8N1, 8E1, 8O1, 7N2, all 16 clocks per bit.
module tb_uart_tx_frame;

  logic       clk;
  logic       reset_n;
  logic [3:0] vld;
  logic [7:0] dat [4];
  logic [3:0] rdy_w, ser_w, busy_w, done_w;

  int n_tests;
  int n_fail;

  logic rs [0:399];
  logic rb [0:399];
  logic rd [0:399];
  logic rr [0:399];

  uart_tx_frame #(
    .FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1)
  ) u_8n1 (
    .clk(clk), .reset_n(reset_n),
    .tx_valid(vld[0]), .tx_data(dat[0]),
    .tx_ready(rdy_w[0]), .tx_serial(ser_w[0]),
    .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );

  uart_tx_frame #(
    .FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1)
  ) u_8e1 (
    .clk(clk), .reset_n(reset_n),
    .tx_valid(vld[1]), .tx_data(dat[1]),
    .tx_ready(rdy_w[1]), .tx_serial(ser_w[1]),
    .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );

  uart_tx_frame #(
    .FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1)
  ) u_8o1 (
    .clk(clk), .reset_n(reset_n),
    .tx_valid(vld[2]), .tx_data(dat[2]),
    .tx_ready(rdy_w[2]), .tx_serial(ser_w[2]),
    .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );

  uart_tx_frame #(
    .FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(7),
    .PARITY(0), .STOP_BITS(2)
  ) u_7n2 (
    .clk(clk), .reset_n(reset_n),
    .tx_valid(vld[3]), .tx_data(dat[3][6:0]),
    .tx_ready(rdy_w[3]), .tx_serial(ser_w[3]),
    .tx_busy(busy_w[3]), .tx_done(done_w[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // c=0 is the sample after the first handshake edge
  task automatic record(input int i, input int n,
                        input int mode, input logic [7:0] d2);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rs[c] = ser_w[i];
      rb[c] = busy_w[i];
      rd[c] = done_w[i];
      rr[c] = rdy_w[i];
      if (mode == 0 && c == 0) vld[i] = 1'b0;
      if (mode >= 1 && c == 0) dat[i] = d2;
      if (mode >= 1 && c == 2) vld[i] = 1'b0;
      if (mode == 2 && c > 2 && c < 151) begin
        vld[i] = c[0];
        dat[i] = 8'($urandom);
      end
      if (mode == 2 && c == 151) vld[i] = 1'b0;
    end
  endtask

  function automatic int count(input int which,
                               input int lo, input int hi,
                               input logic v);
    int k;
    k = 0;
    for (int c = lo; c < hi; c++) begin
      case (which)
        0: if (rs[c] === v) k++;
        1: if (rb[c] === v) k++;
        default: if (rd[c] === v) k++;
      endcase
    end
    return k;
  endfunction

  // par < 0 means no parity slot
  task automatic check_frame(input string nm, input int off,
                             input logic [7:0] d, input int nb,
                             input int par, input int ns);
    int   slots, len, m;
    logic eb;
    slots = 1 + nb + ((par >= 0) ? 1 : 0) + ns;
    len   = slots * 16;
    chk({nm, "_pre"}, 32'(rs[off-1]), 1);
    for (int s = 0; s < slots; s++) begin
      if (s == 0)                        eb = 1'b0;
      else if (s <= nb)                  eb = d[s-1];
      else if (par >= 0 && s == nb + 1)  eb = par[0];
      else                               eb = 1'b1;
      m = count(0, off + s*16, off + s*16 + 16, eb);
      chk($sformatf("%s_slot%0d", nm, s), 32'(m), 16);
    end
    chk({nm, "_busy"}, 32'(count(1, off, off+len, 1'b1)),
        32'(len));
    chk({nm, "_done_n"}, 32'(count(2, off, off+len, 1'b1)), 1);
    chk({nm, "_done_at"}, 32'(rd[off+len-1]), 1);
  endtask

  task automatic run_single(input int i, input logic [7:0] d,
                            input int nb, input int par,
                            input int ns, input string nm);
    int len;
    len = (1 + nb + ((par >= 0) ? 1 : 0) + ns) * 16;
    vld[i] = 1'b1;
    dat[i] = d;
    record(i, len + 2, 0, 8'h00);
    chk({nm, "_hs_rdy"}, 32'(rr[0]), 0);
    chk({nm, "_hs_ser"}, 32'(rs[0]), 1);
    check_frame(nm, 1, d, nb, par, ns);
    chk({nm, "_idle_ser"},  32'(rs[len+1]), 1);
    chk({nm, "_idle_busy"}, 32'(rb[len+1]), 0);
    chk({nm, "_idle_rdy"},  32'(rr[len+1]), 1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    vld     = '0;
    for (int i = 0; i < 4; i++) dat[i] = '0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_ser%0d", i),  32'(ser_w[i]), 1);
      chk($sformatf("rst_rdy%0d", i),  32'(rdy_w[i]), 1);
      chk($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 0);
      chk($sformatf("rst_done%0d", i), 32'(done_w[i]), 0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_single(0, 8'hA5, 8, -1, 1, "n1_a5");
    run_single(1, 8'hA5, 8, 0, 1, "e1_a5");
    run_single(2, 8'hA5, 8, 1, 1, "o1_a5");
    run_single(1, 8'h01, 8, 1, 1, "e1_01");
    run_single(3, 8'h7F, 7, -1, 2, "n2_7f");

    // back-to-back: 0x55 then 0xAA, zero idle gap
    vld[0] = 1'b1;
    dat[0] = 8'h55;
    record(0, 323, 1, 8'hAA);
    chk("b2b_rdy0",   32'(rr[0]), 0);
    chk("b2b_rdy1",   32'(rr[1]), 1);
    chk("b2b_rdy2",   32'(rr[2]), 0);
    chk("b2b_rdy160", 32'(rr[160]), 0);
    chk("b2b_rdy161", 32'(rr[161]), 1);
    check_frame("b2b_a", 1,   8'h55, 8, -1, 1);
    check_frame("b2b_b", 161, 8'hAA, 8, -1, 1);
    chk("b2b_done_tot", 32'(count(2, 0, 323, 1'b1)), 2);
    chk("b2b_idle", 32'(rs[321]), 1);
    chk("b2b_idle_busy", 32'(rb[321]), 0);

    // ignored traffic while the holding register is full
    vld[0] = 1'b1;
    dat[0] = 8'h3C;
    record(0, 363, 2, 8'hC3);
    check_frame("tog_a", 1,   8'h3C, 8, -1, 1);
    check_frame("tog_b", 161, 8'hC3, 8, -1, 1);
    chk("tog_done_tot", 32'(count(2, 0, 363, 1'b1)), 2);
    chk("tog_no_extra", 32'(count(0, 321, 363, 1'b0)), 0);
    chk("tog_rdy_end",  32'(rr[362]), 1);

    // reset during data bit 3 with a byte held
    vld[0] = 1'b1;
    dat[0] = 8'hF7;
    record(0, 70, 1, 8'h5A);
    chk("rst_pre_ser", 32'(ser_w[0]), 0);
    chk("rst_pre_rdy", 32'(rdy_w[0]), 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_ser",  32'(ser_w[0]), 1);
    chk("rst_async_rdy",  32'(rdy_w[0]), 1);
    chk("rst_async_busy", 32'(busy_w[0]), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    record(0, 200, 0, 8'h00);
    chk("rst_after_low",  32'(count(0, 0, 200, 1'b0)), 0);
    chk("rst_after_busy", 32'(count(1, 0, 200, 1'b1)), 0);
    chk("rst_after_done", 32'(count(2, 0, 200, 1'b1)), 0);
    run_single(0, 8'h81, 8, -1, 1, "rst_recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter. Successor to the fixed 8N1 always-enabled transmitter.
- Configurable data width, parity mode and stop-bit count.
- valid/ready byte input with a one-entry holding register, so back-to-back frames go out with zero idle gap.
- Sits between an on-chip byte producer (debug/logging engine) and the board TX pin.

Parameters:
FREQUENCY, 10000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bits/s; CLKS_PER_BIT = FREQUENCY / BAUD_RATE (integer divide)
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
tx_valid  input  1  producer has a character on tx_data
tx_data  input  DATA_BITS  character; sampled only on handshake
tx_ready  output  1  holding register empty; handshake = tx_valid && tx_ready at rising edge
tx_serial  output  1  serial line, idle high, registered
tx_busy  output  1  high whenever FSM not in IDLE
tx_done  output  1  one-cycle pulse at end of each frame's last stop bit

Behaviour:
- Elaboration checks; each illegal value is an elaboration error:
  - CLKS_PER_BIT >= 2
  - DATA_BITS in 5..9
  - PARITY in 0..2
  - STOP_BITS in 1..2
- Bit counter width: $clog2(CLKS_PER_BIT). Bit-index width: $clog2(DATA_BITS).
- Reset (reset_n low, asynchronous):
  - outputs: tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0
  - internal: FSM=IDLE, holding register empty, counters=0
  - reset mid-frame aborts the frame immediately; the line returns high with no stop bit; the pending held byte is discarded.
- Holding register:
  - tx_ready = !hold_full, from a register.
  - Handshake sets hold_full and captures tx_data.
  - hold_full clears when the FSM moves the byte into the shift register.
  - tx_ready is low while full, so fill and drain never coincide.
  - tx_data and tx_valid are ignored while tx_ready=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_serial=1. If hold_full: load shift register, clear hold_full, go START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go DATA.
  - DATA: sends shift[0] (LSB first) for CLKS_PER_BIT cycles per bit, DATA_BITS bits. Then go PARITY if PARITY!=0, else STOP.
  - PARITY: for CLKS_PER_BIT cycles, sends
    - even: XOR of data bits
    - odd: inverted XOR of data bits
  - STOP: tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - On the final cycle, pulse tx_done.
    - If hold_full: load the next byte and go START directly (no idle cycle); else go IDLE.
- Latency:
  - Handshake at edge k with FSM in IDLE and hold empty → hold full after k.
  - Start bit driven from edge k+1.
  - Frame duration is exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Throughput:
  - A second byte can be accepted one cycle after the first leaves the holding register.
  - Continuous streaming gives contiguous frames.
- tx_busy: high from START entry through the last STOP cycle; stays high across back-to-back frames.
- Parity is computed from the captured byte, not from live tx_data.

Test Plan:
- FREQUENCY=16, BAUD_RATE=1, 8N1, send 0xA5 → tx_serial: 16 clocks low, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then 16 clocks high; tx_done pulses once at cycle 160 after start; tx_busy high 160 cycles.
- Same clocking, PARITY=2 with 0xA5 → parity bit 0; PARITY=1 with 0xA5 → parity bit 1; PARITY=2 with 0x01 → parity bit 1; frame length 176 cycles.
- DATA_BITS=7, STOP_BITS=2, PARITY=0, send 0x7F → start, seven 1s, 32 clocks high, frame 160 cycles, tx_done at end of second stop bit.
- 8N1, tx_valid held high with 0x55 then 0xAA → second handshake occurs while first frame is in flight; second start bit immediately follows first stop bit (0 idle cycles); tx_done pulses 160 cycles apart; tx_ready low while holding register full.
- Drop reset_n during bit 3 of DATA with a byte held → tx_serial=1 and tx_ready=1 asynchronously; after release the line stays idle (held byte discarded) until a new handshake.
- tx_valid toggled while tx_ready=0 with changing tx_data → no extra frames; transmitted bytes equal only the handshaken values.
